npu_dout_axis_packer: RTL and testbench

//  Downstream of the crossbar readout path: takes 6-bit ADC DOUT samples (one per selected BL) and

---
 rtl/npu_pkg.sv | 33 +++
 rtl/npu_sync_fifo.sv | 66 ++++++
 rtl/npu_dout_axis_packer.sv | 197 +++++++++++++++++++
 tb/tb_npu_dout_axis_packer.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/npu_pkg.sv
// -----------------------------------------------------------------------------
// npu_pkg
//   Shared types and constants for the DOUT -> AXI-Stream packer.
//   - DOUT_WIDTH / LANE_WIDTH : ADC sample width and per-lane stream width
//   - STRB_FULL / STRB_TAIL   : tstrb for a two-sample beat / odd single-sample tail
//   - pk_state_t              : packer FSM states
//   - beat_t                  : one stream beat as stored in the beat FIFO
// -----------------------------------------------------------------------------
package npu_pkg;

    localparam int unsigned DOUT_WIDTH = 6;
    localparam int unsigned LANE_WIDTH = 8;

    localparam logic [1:0] STRB_FULL = 2'b11;
    localparam logic [1:0] STRB_TAIL = 2'b01;

    typedef enum logic [1:0] {
        PK_IDLE    = 2'd0,
        PK_COLLECT = 2'd1,
        PK_DRAIN   = 2'd2
    } pk_state_t;

    typedef struct packed {
        logic        tlast;
        logic [1:0]  tstrb;
        logic [15:0] tdata;
    } beat_t;

    function automatic logic [LANE_WIDTH-1:0] zext_sample(input logic [DOUT_WIDTH-1:0] s);
        return {{(LANE_WIDTH - DOUT_WIDTH){1'b0}}, s};
    endfunction

endpackage

// File: rtl/npu_sync_fifo.sv
// -----------------------------------------------------------------------------
// npu_sync_fifo
//   Single-clock FIFO with flop storage. The head entry is read straight from
//   the storage flops, so an entry is visible on rd_data the cycle after it is
//   written. A write while full is accepted only if a read happens the same
//   cycle; otherwise it is ignored (the caller decides what that means).
// Ports
//   clk, rstn        : clock, async active-low reset (flushes the FIFO)
//   wr_en, wr_data   : write request and data
//   rd_en            : pop the head entry (ignored when empty)
//   rd_data          : head entry
//   full, empty      : occupancy flags
// -----------------------------------------------------------------------------
module npu_sync_fifo #(
    parameter int unsigned WIDTH = 19,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_wr, do_rd;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign do_rd = rd_en && !empty;
    assign do_wr = wr_en && (!full || do_rd);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: nothing is visible until a pointer moves.
    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end

    assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/npu_dout_axis_packer.sv
// -----------------------------------------------------------------------------
// npu_dout_axis_packer
//   Packs 6-bit ADC DOUT samples two per 16-bit AXI-Stream beat, one frame per
//   start, tlast on the final beat. A beat FIFO absorbs host backpressure; the
//   ADC cannot be stalled, so a beat that finds the FIFO full is dropped and
//   the sticky overflow flag is raised.
// Ports
//   clk, rstn          : clock, async active-low reset
//   start, frame_len   : begin a frame of frame_len samples (0..MAX_NUM_BL)
//   sample_valid/data  : DOUT sample strobe and value
//   m00_axis_*         : AXI-Stream master (tdata[7:0] even sample, [15:8] odd)
//   busy               : frame in progress
//   done               : 1-cycle pulse once the tlast beat is accepted
//   overflow           : sticky, a beat was dropped; cleared by an accepted start
//   drop_cnt           : only with NPU_PACKER_DROPCNT_EN defined; saturating count
//                        of dropped beats, cleared by an accepted start
// -----------------------------------------------------------------------------
module npu_dout_axis_packer
    import npu_pkg::*;
#(
    parameter int unsigned AXIS_DATA_WIDTH = 16,
    parameter int unsigned MAX_NUM_BL      = 256,
    parameter int unsigned FIFO_DEPTH      = 16
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           start,
    input  logic [$clog2(MAX_NUM_BL+1)-1:0] frame_len,
    input  logic                           sample_valid,
    input  logic [DOUT_WIDTH-1:0]          sample_data,
    output logic                           m00_axis_tvalid,
    output logic [AXIS_DATA_WIDTH-1:0]     m00_axis_tdata,
    output logic [AXIS_DATA_WIDTH/8-1:0]   m00_axis_tstrb,
    output logic                           m00_axis_tlast,
    input  logic                           m00_axis_tready,
    output logic                           busy,
    output logic                           done,
    output logic                           overflow
`ifdef NPU_PACKER_DROPCNT_EN
    ,
    output logic [15:0]                    drop_cnt
`endif
);

    localparam int unsigned CW = $clog2(MAX_NUM_BL + 1);

    pk_state_t       state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]   len_q, len_d;
    logic [LANE_WIDTH-1:0] low_q, low_d;
    logic            ovf_q, ovf_d;
    logic            done_q, done_d;

    beat_t           wr_beat, rd_beat;
    logic            beat_wr, beat_drop;
    logic            fifo_full, fifo_empty, fifo_rd;
    logic [CW-1:0]   cnt_next;
    logic            last_sample;

`ifdef NPU_PACKER_DROPCNT_EN
    logic [15:0]     drop_cnt_q, drop_cnt_d;
`endif

    assign fifo_rd   = !fifo_empty && m00_axis_tready;
    // A full FIFO still takes a write when the head is popped the same cycle.
    assign beat_drop = beat_wr && fifo_full && !fifo_rd;

    assign cnt_next    = cnt_q + 1'b1;
    assign last_sample = (cnt_next == len_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        low_d   = low_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        beat_wr = 1'b0;
        wr_beat = '0;

        unique case (state_q)
            PK_IDLE: begin
                if (start) begin
                    ovf_d = 1'b0;
                    if (frame_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        len_d   = frame_len;
                        cnt_d   = '0;
                        state_d = PK_COLLECT;
                    end
                end
            end
            PK_COLLECT: begin
                if (sample_valid) begin
                    cnt_d = cnt_next;
                    if (!cnt_q[0]) begin
                        low_d = zext_sample(sample_data);
                        if (last_sample) begin
                            beat_wr       = 1'b1;
                            wr_beat.tlast = 1'b1;
                            wr_beat.tstrb = STRB_TAIL;
                            wr_beat.tdata = {{LANE_WIDTH{1'b0}}, zext_sample(sample_data)};
                        end
                    end else begin
                        beat_wr       = 1'b1;
                        wr_beat.tlast = last_sample;
                        wr_beat.tstrb = STRB_FULL;
                        wr_beat.tdata = {zext_sample(sample_data), low_q};
                    end
                    if (last_sample) begin
                        // If the tlast beat itself is dropped there is nothing to
                        // wait for downstream, so the frame closes right away.
                        if (beat_drop) begin
                            done_d  = 1'b1;
                            state_d = PK_IDLE;
                        end else begin
                            state_d = PK_DRAIN;
                        end
                    end
                end
            end
            PK_DRAIN: begin
                // Earlier frames fully drained before IDLE, so any tlast seen
                // here belongs to the current frame.
                if (fifo_rd && rd_beat.tlast) begin
                    done_d  = 1'b1;
                    state_d = PK_IDLE;
                end
            end
            default: state_d = PK_IDLE;
        endcase

        if (beat_drop) ovf_d = 1'b1;
    end

`ifdef NPU_PACKER_DROPCNT_EN
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (state_q == PK_IDLE && start) begin
            drop_cnt_d = '0;
        end else if (beat_drop && drop_cnt_q != 16'hFFFF) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) drop_cnt_q <= '0;
        else       drop_cnt_q <= drop_cnt_d;
    end

    assign drop_cnt = drop_cnt_q;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= PK_IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            low_q   <= '0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            low_q   <= low_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    npu_sync_fifo #(
        .WIDTH ($bits(beat_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_beat_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .wr_en   (beat_wr),
        .wr_data (wr_beat),
        .rd_en   (fifo_rd),
        .rd_data (rd_beat),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Head of the FIFO is the registered output stage; mask it while empty.
    assign m00_axis_tvalid = !fifo_empty;
    assign m00_axis_tdata  = fifo_empty ? '0 : rd_beat.tdata;
    assign m00_axis_tstrb  = fifo_empty ? '0 : rd_beat.tstrb;
    assign m00_axis_tlast  = !fifo_empty && rd_beat.tlast;

    assign busy     = (state_q != PK_IDLE);
    assign done     = done_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_npu_dout_axis_packer.sv
module tb_npu_dout_axis_packer;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic [8:0]  frame_len = '0;
    logic        sample_valid = 1'b0;
    logic [5:0]  sample_data = '0;
    logic        tvalid;
    logic [15:0] tdata;
    logic [1:0]  tstrb;
    logic        tlast;
    logic        tready = 1'b0;
    logic        busy, done, overflow;
`ifdef NPU_PACKER_DROPCNT_EN
    logic [15:0] drop_cnt;
`endif

    npu_dout_axis_packer dut (
        .clk             (clk),
        .rstn            (rstn),
        .start           (start),
        .frame_len       (frame_len),
        .sample_valid    (sample_valid),
        .sample_data     (sample_data),
        .m00_axis_tvalid (tvalid),
        .m00_axis_tdata  (tdata),
        .m00_axis_tstrb  (tstrb),
        .m00_axis_tlast  (tlast),
        .m00_axis_tready (tready),
        .busy            (busy),
        .done            (done),
        .overflow        (overflow)
`ifdef NPU_PACKER_DROPCNT_EN
        ,
        .drop_cnt        (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Collector: accepted beats as {tlast, tstrb, tdata} and done pulses.
    logic [18:0] got_q[$];
    int          done_cnt = 0;
    always @(negedge clk) begin
        if (tvalid && tready) got_q.push_back({tlast, tstrb, tdata});
        if (done) done_cnt++;
    end

    typedef struct {
        int               len;
        logic [3:0][5:0]  s;
        int               nb;
        logic [1:0][18:0] b;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int len);
        start = 1'b1;
        frame_len = 9'(len);
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [5:0] s);
        sample_valid = 1'b1;
        sample_data = s;
        tick();
        sample_valid = 1'b0;
    endtask

    task automatic wait_done(input string name, input int base);
        for (int i = 0; i < 600 && done_cnt == base; i++) tick();
        tick();
        chk({name, " done_pulses"}, 32'(done_cnt - base), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          gb, base, occ, dropped;
        logic [18:0] exp_q[$];
        logic [18:0] b;
        logic [5:0]  prev;
        logic [15:0] held;

        vecs[0] = '{len: 4, s: {6'd4, 6'd3, 6'd2, 6'd1}, nb: 2,
                    b: {{1'b1, 2'b11, 16'h0403}, {1'b0, 2'b11, 16'h0201}}};
        vecs[1] = '{len: 3, s: {6'd0, 6'h2A, 6'h01, 6'h3F}, nb: 2,
                    b: {{1'b1, 2'b01, 16'h002A}, {1'b0, 2'b11, 16'h013F}}};
        vecs[2] = '{len: 1, s: {6'd0, 6'd0, 6'd0, 6'h15}, nb: 1,
                    b: {19'd0, {1'b1, 2'b01, 16'h0015}}};
        vecs[3] = '{len: 2, s: {6'd0, 6'd0, 6'h3F, 6'h3F}, nb: 1,
                    b: {19'd0, {1'b1, 2'b11, 16'h3F3F}}};

        // Reset state
        rstn = 1'b0;
        tick();
        tick();
        chk("rst tvalid", 32'(tvalid), 0);
        chk("rst tdata", 32'(tdata), 0);
        chk("rst tstrb", 32'(tstrb), 0);
        chk("rst tlast", 32'(tlast), 0);
        chk("rst busy", 32'(busy), 0);
        chk("rst done", 32'(done), 0);
        chk("rst overflow", 32'(overflow), 0);
        rstn = 1'b1;
        tick();

        // Table-driven short frames with tready held high
        tready = 1'b1;
        for (int v = 0; v < 4; v++) begin
            gb = got_q.size();
            base = done_cnt;
            do_start(vecs[v].len);
            chk($sformatf("v%0d busy", v), 32'(busy), 1);
            for (int k = 0; k < vecs[v].len; k++) send(vecs[v].s[k]);
            wait_done($sformatf("v%0d", v), base);
            chk($sformatf("v%0d nbeats", v), 32'(got_q.size() - gb), 32'(vecs[v].nb));
            for (int k = 0; k < vecs[v].nb; k++)
                if (gb + k < got_q.size())
                    chk($sformatf("v%0d beat%0d", v, k), 32'(got_q[gb + k]), 32'(vecs[v].b[k]));
            chk($sformatf("v%0d busy_end", v), 32'(busy), 0);
            chk($sformatf("v%0d overflow", v), 32'(overflow), 0);
        end

        // frame_len == 0: done the next cycle, no beats, stays idle
        gb = got_q.size();
        do_start(0);
        chk("len0 done", 32'(done), 1);
        chk("len0 busy", 32'(busy), 0);
        tick();
        chk("len0 done_low", 32'(done), 0);
        chk("len0 tvalid", 32'(tvalid), 0);
        chk("len0 nbeats", 32'(got_q.size() - gb), 0);

        // start mid-frame is ignored; also checks one-cycle write-to-output latency
        gb = got_q.size();
        base = done_cnt;
        do_start(4);
        send(6'd1);
        send(6'd2);
        chk("mid latency tvalid", 32'(tvalid), 1);
        chk("mid latency tdata", 32'(tdata), 32'h0201);
        do_start(2);
        send(6'd3);
        send(6'd4);
        wait_done("mid", base);
        chk("mid nbeats", 32'(got_q.size() - gb), 2);
        if (got_q.size() >= gb + 2) begin
            chk("mid beat0", 32'(got_q[gb]), 32'({1'b0, 2'b11, 16'h0201}));
            chk("mid beat1", 32'(got_q[gb + 1]), 32'({1'b1, 2'b11, 16'h0403}));
        end

        // Backpressure hold, then reset mid-frame
        tready = 1'b0;
        base = done_cnt;
        do_start(8);
        for (int k = 1; k <= 5; k++) send(6'(k));
        chk("hold tvalid", 32'(tvalid), 1);
        held = tdata;
        chk("hold tdata0", 32'(tdata), 32'h0201);
        tick();
        tick();
        chk("hold tvalid2", 32'(tvalid), 1);
        chk("hold tdata2", 32'(tdata), 32'(held));
        chk("hold tlast", 32'(tlast), 0);
        #2;
        rstn = 1'b0;
        #1;
        chk("midrst tvalid", 32'(tvalid), 0);
        chk("midrst tdata", 32'(tdata), 0);
        chk("midrst busy", 32'(busy), 0);
        chk("midrst done", 32'(done), 0);
        tick();
        rstn = 1'b1;
        tick();
        chk("midrst no_done", 32'(done_cnt - base), 0);
        tready = 1'b1;
        gb = got_q.size();
        base = done_cnt;
        do_start(2);
        send(6'h11);
        send(6'h22);
        wait_done("postrst", base);
        chk("postrst nbeats", 32'(got_q.size() - gb), 1);
        if (got_q.size() > gb)
            chk("postrst beat", 32'(got_q[gb]), 32'({1'b1, 2'b11, 16'h2211}));

        // 256-sample frame with backpressure and overflow
        gb = got_q.size();
        base = done_cnt;
        occ = 0;
        dropped = 0;
        prev = '0;
        tready = 1'b0;
        do_start(256);
        for (int i = 0; i < 256; i++) begin
            tready = (i < 40) ? 1'b0 : (i >= 216) ? 1'b1 : ((i % 4) == 0);
            sample_valid = 1'b1;
            sample_data = 6'(i);
            if (occ > 0 && tready) occ--;
            if (i % 2 == 1) begin
                b = {(i == 255), 2'b11, 2'b00, 6'(i), 2'b00, prev};
                if (occ < 16) begin
                    occ++;
                    exp_q.push_back(b);
                end else begin
                    dropped++;
                end
            end
            prev = 6'(i);
            tick();
        end
        sample_valid = 1'b0;
        tready = 1'b1;
        wait_done("ovf", base);
        chk("ovf overflow", 32'(overflow), 1);
        chk("ovf nbeats", 32'(got_q.size() - gb), 32'(exp_q.size()));
        for (int k = 0; k < exp_q.size(); k++)
            if (gb + k < got_q.size() && got_q[gb + k] !== exp_q[k])
                chk($sformatf("ovf beat%0d", k), 32'(got_q[gb + k]), 32'(exp_q[k]));
        if (got_q.size() > gb)
            chk("ovf last_tlast", 32'(got_q[got_q.size() - 1][18]), 1);
`ifdef NPU_PACKER_DROPCNT_EN
        chk("ovf drop_cnt", 32'(drop_cnt), 32'(dropped));
`endif

        // An accepted start clears the sticky flag
        base = done_cnt;
        do_start(2);
        chk("clr overflow", 32'(overflow), 0);
`ifdef NPU_PACKER_DROPCNT_EN
        chk("clr drop_cnt", 32'(drop_cnt), 0);
`endif
        send(6'd5);
        send(6'd6);
        wait_done("clr", base);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
